lambda_lexer_stream: RTL and testbench

//  Parametrised streaming lexer for the lambda-term front end: consumes ASCII bytes over a

---
 rtl/lambda_lexer_stream_if.sv | 29 ++
 rtl/lambda_lexer_stream.sv | 175 +++++++++++++++++
 tb/tb_lambda_lexer_stream.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lambda_lexer_stream_if.sv
// Byte-in / token-out bundle for the streaming lambda-term lexer.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds its data until then.
interface lambda_lexer_stream_if #(
    parameter int ID_CHARS = 4,
    parameter int DEPTH    = 8
);
    localparam int TOK_W = 16 + 8 * ID_CHARS;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [TOK_W-1:0] tok_data;
    logic             tok_valid;
    logic             tok_ready;
    logic [CNT_W-1:0] tok_count;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output in_data, in_valid, tok_ready,
        input  in_ready, tok_data, tok_valid, tok_count, busy, dbg_state
    );

    modport slave (
        input  in_data, in_valid, tok_ready,
        output in_ready, tok_data, tok_valid, tok_count, busy, dbg_state
    );
endinterface

// File: rtl/lambda_lexer_stream.sv
// Streaming lexer: groups identifier bytes, classifies punctuation, queues tokens in a FIFO.
// Token layout: [7:0] kind, [15:8] len, then one payload byte per stored identifier char.
module lambda_lexer_stream #(
    parameter int ID_CHARS = 4,
    parameter int DEPTH    = 8
) (
    input  logic clk_25mhz,
    input  logic reset,
    lambda_lexer_stream_if.slave bus
);
    localparam int TOK_W = 16 + 8 * ID_CHARS;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [7:0] K_EOF    = 8'd0;
    localparam logic [7:0] K_LAMBDA = 8'd1;
    localparam logic [7:0] K_DOT    = 8'd2;
    localparam logic [7:0] K_LPAREN = 8'd3;
    localparam logic [7:0] K_RPAREN = 8'd4;
    localparam logic [7:0] K_EQUALS = 8'd5;
    localparam logic [7:0] K_IDENT  = 8'd6;
    localparam logic [7:0] K_ERROR  = 8'd7;

    typedef enum logic [1:0] {S_IDLE, S_IDENT, S_DONE} state_t;
    typedef logic [ID_CHARS-1:0][7:0] chars_t;

    state_t           state_q, state_d;
    logic [7:0]       len_q, len_d;
    chars_t           chars_q, chars_d;
    logic             pend_valid_q, pend_valid_d;
    logic [TOK_W-1:0] pend_tok_q, pend_tok_d;
    logic [TOK_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifo_full, fifo_empty, accept, push, pop;
    logic [TOK_W-1:0] push_tok;
    logic [7:0]       b;

    function automatic logic is_ident(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a) ||
               (c >= 8'h30 && c <= 8'h39) || (c == 8'h5f);
    endfunction

    function automatic logic is_space(input logic [7:0] c);
        return (c == 8'd32) || (c == 8'd9) || (c == 8'd10) || (c == 8'd13);
    endfunction

    function automatic logic [TOK_W-1:0] mk_tok(input logic [7:0] kind, input logic [7:0] len,
                                                 input chars_t chars);
        return {chars, len, kind};
    endfunction

    // Single-byte tokens: punctuation carries no payload, anything unknown becomes ERROR.
    function automatic logic [TOK_W-1:0] byte_tok(input logic [7:0] c);
        logic [7:0] kind;
        logic [7:0] len;
        chars_t     chars;
        len   = 8'd0;
        chars = '0;
        case (c)
            8'h5c:   kind = K_LAMBDA;
            8'h2e:   kind = K_DOT;
            8'h28:   kind = K_LPAREN;
            8'h29:   kind = K_RPAREN;
            8'h3d:   kind = K_EQUALS;
            default: kind = K_ERROR;
        endcase
        if (kind == K_ERROR) begin
            len      = 8'd1;
            chars[0] = c;
        end
        return mk_tok(kind, len, chars);
    endfunction

    assign b          = bus.in_data;
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && bus.tok_ready;
    assign accept     = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !pend_valid_q && !fifo_full;
    assign bus.tok_valid = !fifo_empty;
    assign bus.tok_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.tok_count = count_q;
    assign bus.busy      = (state_q == S_IDENT) || pend_valid_q;
    assign bus.dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        chars_d      = chars_q;
        pend_valid_d = pend_valid_q;
        pend_tok_d   = pend_tok_q;
        push         = 1'b0;
        push_tok     = '0;
        // in_ready is low while pend is held, so pend and a new byte never compete for the write.
        if (pend_valid_q) begin
            if (!fifo_full) begin
                push         = 1'b1;
                push_tok     = pend_tok_q;
                pend_valid_d = 1'b0;
            end
        end else if (accept) begin
            case (state_q)
                S_IDENT: begin
                    if (is_ident(b)) begin
                        if (len_q != 8'hff) len_d = len_q + 8'd1;
                        for (int i = 0; i < ID_CHARS; i++) begin
                            if (len_q == 8'(i)) chars_d[i] = b;
                        end
                    end else begin
                        push     = 1'b1;
                        push_tok = mk_tok(K_IDENT, len_q, chars_q);
                        state_d  = S_IDLE;
                        if (b == 8'd0) begin
                            pend_valid_d = 1'b1;
                            pend_tok_d   = mk_tok(K_EOF, 8'd0, '0);
                            state_d      = S_DONE;
                        end else if (!is_space(b)) begin
                            pend_valid_d = 1'b1;
                            pend_tok_d   = byte_tok(b);
                        end
                    end
                end
                default: begin
                    if (is_ident(b)) begin
                        state_d    = S_IDENT;
                        len_d      = 8'd1;
                        chars_d    = '0;
                        chars_d[0] = b;
                    end else if (b == 8'd0) begin
                        if (state_q != S_DONE) begin
                            push     = 1'b1;
                            push_tok = mk_tok(K_EOF, 8'd0, '0);
                        end
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                        if (!is_space(b)) begin
                            push     = 1'b1;
                            push_tok = byte_tok(b);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            chars_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_tok_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            chars_q      <= chars_d;
            pend_valid_q <= pend_valid_d;
            pend_tok_q   <= pend_tok_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_25mhz) begin
        if (push) mem_q[wr_ptr_q] <= push_tok;
    end
endmodule

// File: tb/tb_lambda_lexer_stream.sv
// Bench for lambda_lexer_stream: directed scenarios plus random byte streams,
// tokens compared against a whole-string tokenizer model.
module tb_lambda_lexer_stream;
    localparam int ID_CHARS = 4;
    localparam int DEPTH    = 4;
    localparam int TOK_W    = 16 + 8 * ID_CHARS;

    logic clk_25mhz = 1'b0;
    logic reset     = 1'b1;

    always #20 clk_25mhz = ~clk_25mhz;

    lambda_lexer_stream_if #(.ID_CHARS(ID_CHARS), .DEPTH(DEPTH)) bus ();

    lambda_lexer_stream #(.ID_CHARS(ID_CHARS), .DEPTH(DEPTH)) dut (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .bus       (bus)
    );

    logic [TOK_W-1:0] exp_q[$];
    logic [7:0]       seq[$];
    int               checks_total  = 0;
    int               checks_passed = 0;
    bit               m_done        = 1'b0;
    bit               rand_ready    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_id(input logic [7:0] c);
        return c inside {[8'h61:8'h7a], [8'h41:8'h5a], [8'h30:8'h39], 8'h5f};
    endfunction

    function automatic logic [TOK_W-1:0] mk_ident(input logic [7:0] q[$], input int start, input int len);
        logic [TOK_W-1:0] t;
        t        = '0;
        t[7:0]   = 8'd6;
        t[15:8]  = (len > 255) ? 8'd255 : 8'(len);
        for (int k = 0; k < ID_CHARS && k < len; k++) t[16 + 8 * k +: 8] = q[start + k];
        return t;
    endfunction

    function automatic logic [TOK_W-1:0] byte_tok(input logic [7:0] c);
        string            punct;
        logic [TOK_W-1:0] t;
        punct  = "\\.()=";
        t      = '0;
        t[7:0] = 8'd7;
        for (int p = 0; p < 5; p++) if (punct[p] == c) t[7:0] = 8'(p + 1);
        if (t[7:0] == 8'd7) begin
            t[15:8]  = 8'd1;
            t[23:16] = c;
        end
        return t;
    endfunction

    // Tokenizes a whole byte sequence; an identifier with no terminator yet emits nothing.
    function automatic void model(input logic [7:0] q[$]);
        int i;
        i = 0;
        while (i < q.size()) begin
            logic [7:0] c;
            c = q[i];
            if (is_id(c)) begin
                int j;
                j = i;
                while (j < q.size() && is_id(q[j])) j++;
                if (j < q.size()) exp_q.push_back(mk_ident(q, i, j - i));
                m_done = 1'b0;
                i = j;
            end else begin
                if (c == 8'd0) begin
                    if (!m_done) exp_q.push_back('0);
                    m_done = 1'b1;
                end else begin
                    m_done = 1'b0;
                    if (!(c inside {8'd32, 8'd9, 8'd10, 8'd13})) exp_q.push_back(byte_tok(c));
                end
                i++;
            end
        end
    endfunction

    function automatic void push_str(input string s);
        for (int k = 0; k < s.len(); k++) seq.push_back(s[k]);
    endfunction

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] c);
        int n;
        n = 0;
        bus.in_data  = c;
        bus.in_valid = 1'b1;
        @(negedge clk_25mhz);
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk_25mhz);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.tok_ready = 1'b1;
        @(negedge clk_25mhz);
        while ((exp_q.size() != 0 || bus.tok_count != 0) && n < 200) begin
            @(negedge clk_25mhz);
            n++;
        end
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_count"}, 64'(bus.tok_count), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        @(posedge clk_25mhz);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_25mhz) begin : monitor
        logic [TOK_W-1:0] e;
        if (!reset && bus.tok_valid && bus.tok_ready) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : {TOK_W{1'bx}};
            check("tok_stream", 64'(bus.tok_data), 64'(e));
        end
    end

    always @(posedge clk_25mhz) begin
        #1;
        if (rand_ready) bus.tok_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.tok_ready = 1'b0;
        repeat (2) @(negedge clk_25mhz);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_tok_valid", 64'(bus.tok_valid), 64'd0);
        check("rst_tok_data", 64'(bus.tok_data), 64'd0);
        check("rst_tok_count", 64'(bus.tok_count), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        @(posedge clk_25mhz);
        #1;

        // T1: full expression, then repeated NULs yield a single EOF
        bus.tok_ready = 1'b1;
        seq.delete();
        push_str(" id=\\x.x");
        seq.push_back(8'd0); seq.push_back(8'd0); seq.push_back(8'd0);
        model(seq);
        send_seq();
        drain("t1");

        // T2: closing paren after an identifier is held for one cycle
        seq.delete();
        push_str("(f x)");
        model(seq);
        for (int k = 0; k < 4; k++) send_byte(seq[k]);
        send_byte(8'h29);
        @(negedge clk_25mhz);
        check("t2_pend_in_ready", 64'(bus.in_ready), 64'd0);
        check("t2_pend_busy", 64'(bus.busy), 64'd1);
        @(negedge clk_25mhz);
        check("t2_after_in_ready", 64'(bus.in_ready), 64'd1);
        check("t2_after_busy", 64'(bus.busy), 64'd0);
        @(posedge clk_25mhz);
        #1;
        drain("t2");

        // T3: truncated payload and saturating length
        seq.delete();
        push_str("abcdefg ");
        model(seq);
        send_seq();
        drain("t3a");
        seq.delete();
        for (int k = 0; k < 300; k++) seq.push_back(8'h61);
        seq.push_back(8'd32);
        model(seq);
        send_seq();
        drain("t3b");

        // T4: backpressure with a full FIFO
        bus.tok_ready = 1'b0;
        seq.delete();
        push_str("\\.()=\\");
        model(seq);
        for (int k = 0; k < 4; k++) send_byte(seq[k]);
        @(negedge clk_25mhz);
        check("t4_full_count", 64'(bus.tok_count), 64'd4);
        check("t4_full_in_ready", 64'(bus.in_ready), 64'd0);
        check("t4_full_tok_valid", 64'(bus.tok_valid), 64'd1);
        bus.in_data  = seq[4];
        bus.in_valid = 1'b1;
        @(negedge clk_25mhz);
        check("t4_stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("t4_stall_count", 64'(bus.tok_count), 64'd4);
        @(posedge clk_25mhz);
        #1;
        bus.tok_ready = 1'b1;
        send_byte(seq[4]);
        send_byte(seq[5]);
        drain("t4");

        // T5: error byte splits identifiers
        seq.delete();
        push_str("a#b");
        seq.push_back(8'd0);
        model(seq);
        rand_ready = 1'b1;
        send_seq();
        rand_ready = 1'b0;
        drain("t5");

        // T6: reset mid-identifier with tokens queued
        bus.tok_ready = 1'b0;
        seq.delete();
        push_str("()abc");
        model(seq);
        send_seq();
        @(negedge clk_25mhz);
        check("t6_pre_count", 64'(bus.tok_count), 64'd2);
        check("t6_pre_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        m_done = 1'b0;
        @(negedge clk_25mhz);
        check("t6_rst_tok_valid", 64'(bus.tok_valid), 64'd0);
        check("t6_rst_count", 64'(bus.tok_count), 64'd0);
        check("t6_rst_busy", 64'(bus.busy), 64'd0);
        check("t6_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("t6_rst_tok_data", 64'(bus.tok_data), 64'd0);
        reset = 1'b0;
        @(posedge clk_25mhz);
        #1;
        bus.tok_ready = 1'b1;
        seq.delete();
        push_str("z ");
        model(seq);
        send_seq();
        drain("t6");

        // Random streams with random output backpressure
        for (int r = 0; r < 8; r++) begin
            string alpha;
            int    n;
            alpha = "abXY_09 \t()\\.=#@";
            seq.delete();
            n = $urandom_range(10, 40);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 9) == 0) seq.push_back(8'd0);
                else seq.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
            end
            seq.push_back(8'd0);
            model(seq);
            rand_ready = 1'b1;
            send_seq();
            rand_ready = 1'b0;
            drain("rand");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
